dmem_responder: RTL and testbench

Data-memory responder for the MEM stage of the 32-bit pipelined MIPS core. It accepts the MEM stage's MemRead/MemWrite requests on the existing Addr/Wdata/Rdata interface and services them from an internal word-addressed RAM after a fixed, parameterised number of wait states. It returns a one-cycle MemReady pulse and a Stall level, so the pipeline can freeze while an access is in flight.

---
 rtl/dmem_responder_pkg.sv | 25 ++
 rtl/dmem_responder_if.sv | 30 +++
 rtl/dmem_responder_array.sv | 29 ++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : dmem_pkg                                                 |
// | Description : Shared types and constants for the data-memory responder |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package dmem_pkg;

    localparam int DMEM_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmemState_e;

    // A zero-wait build never enters WAIT, but the counter still needs one bit.
    function automatic int dmemCntWidth(input int waitCycles);
        int w;
        w = $clog2(waitCycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : dmem_if                                                  |
// | Description : MEM-stage request/response bus of the data memory        |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
interface dmem_if;
    import dmem_pkg::*;

    logic               MemRead;
    logic               MemWrite;
    logic [DMEM_DW-1:0] Addr;
    logic [DMEM_DW-1:0] Wdata;
    logic [DMEM_DW-1:0] Rdata;
    logic               MemReady;
    logic               Stall;
    logic               AddrErr;

    modport master (
        output MemRead, MemWrite, Addr, Wdata,
        input  Rdata, MemReady, Stall, AddrErr
    );

    modport slave (
        input  MemRead, MemWrite, Addr, Wdata,
        output Rdata, MemReady, Stall, AddrErr
    );

endinterface
`default_nettype wire

// File: rtl/dmem_responder_array.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : dmem_array                                               |
// | Description : Single-port synchronous RAM, read-first, no reset        |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  wire logic                  clk,
    input  wire logic                  we,
    input  wire logic [DEPTH_LOG2-1:0] addr,
    input  wire logic [DMEM_DW-1:0]    wdata,
    output logic      [DMEM_DW-1:0]    rdata
);

    logic [DMEM_DW-1:0] r_mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : dmem_responder                                           |
// | Description : MEM-stage data-memory responder with fixed wait states.  |
// |               Optional define DMEM_ALIGN_CHECK_EN enables misaligned   |
// |               access detection (AddrErr).                              |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    dmem_if.slave     bus
);

    localparam int c_CNT_W = dmemCntWidth(WAIT_CYCLES);

    localparam logic [1:0] c_IDLE = IDLE;
    localparam logic [1:0] c_WAIT = WAIT;
    localparam logic [1:0] c_RESP = RESP;

    localparam logic [c_CNT_W-1:0] c_WAIT_LAST =
        c_CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_showRam;
    logic [DMEM_DW-1:0]    r_lastRdata;

    logic                  w_req;
    logic                  w_enterResp;
    logic                  w_misaligned;
    logic                  w_ramWe;
    logic                  w_readCommit;
    logic [DEPTH_LOG2-1:0] w_index;
    logic [DMEM_DW-1:0]    w_ramRdata;
    logic                  w_unusedAddr;

    assign w_req        = bus.MemRead | bus.MemWrite;
    assign w_index      = bus.Addr[DEPTH_LOG2+1:2];
    assign w_unusedAddr = ^{bus.Addr[DMEM_DW-1:DEPTH_LOG2+2], bus.Addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misaligned = |bus.Addr[1:0];
`else
    assign w_misaligned = 1'b0;
`endif

    // Leaving WAIT does not depend on the request: a dropped request still
    // runs to RESP, it just commits nothing.
    always_comb begin
        w_enterResp = 1'b0;
        case (r_state)
            c_IDLE:  w_enterResp = w_req && (WAIT_CYCLES == 0);
            c_WAIT:  w_enterResp = (r_cnt == c_WAIT_LAST);
            default: w_enterResp = 1'b0;
        endcase
    end

    // Read+write together is a write; misaligned accesses never commit.
    assign w_ramWe      = w_enterResp & bus.MemWrite & ~w_misaligned;
    assign w_readCommit = w_enterResp & bus.MemRead & ~bus.MemWrite & ~w_misaligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        r_cnt   <= '0;
                        r_state <= (WAIT_CYCLES == 0) ? c_RESP : c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (w_enterResp) begin
                        r_state <= c_RESP;
                    end
                    if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_RESP:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // The RAM output register carries the fresh word during RESP; it is
    // captured into r_lastRdata as RESP ends so Rdata holds afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_showRam   <= 1'b0;
            r_lastRdata <= '0;
        end else begin
            if (r_showRam) begin
                r_lastRdata <= w_ramRdata;
            end
            r_showRam <= w_readCommit;
        end
    end

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (w_ramWe),
        .addr  (w_index),
        .wdata (bus.Wdata),
        .rdata (w_ramRdata)
    );

`ifdef DMEM_ALIGN_CHECK_EN
    logic r_addrErr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addrErr <= 1'b0;
        end else begin
            r_addrErr <= w_enterResp & w_req & w_misaligned;
        end
    end

    assign bus.AddrErr = r_addrErr;
`else
    assign bus.AddrErr = 1'b0;
`endif

    assign bus.Rdata    = r_showRam ? w_ramRdata : r_lastRdata;
    assign bus.MemReady = (r_state == c_RESP);
    assign bus.Stall    = w_req & ~bus.MemReady;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_dmem_responder                                        |
// | Description : Directed scoreboard bench for dmem_responder (2 and 0    |
// |               wait-state instances)                                    |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_dmem_responder;
    import dmem_pkg::*;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_if busA ();
    dmem_if busB ();

    dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (busA)
    );

    dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (busB)
    );

    int          nChecks = 0;
    int          nErrors = 0;
    logic [31:0] modelA [int];
    logic [31:0] modelB [int];
    logic [31:0] qA [$];
    logic [31:0] qB [$];
    logic [31:0] lastRdA = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access on the 2-wait instance; starts just after a rising edge in IDLE.
    task automatic accessA(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic expErr);
        int          idx;
        logic        done;
        logic [31:0] exp;
        idx  = int'(addr[9:2]);
        done = 1'b0;
        busA.MemRead  = rd;
        busA.MemWrite = wr;
        busA.Addr     = addr;
        busA.Wdata    = wdata;
        if (rd && !wr) qA.push_back(modelA.exists(idx) ? modelA[idx] : 32'h0);
        for (int cyc = 0; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (busA.MemReady) begin
                check("latencyA", cyc, 3);
                check("stallRespA", {31'b0, busA.Stall}, 0);
                check("addrErrRespA", {31'b0, busA.AddrErr}, {31'b0, expErr});
                if (rd && !wr) begin
                    exp = qA.pop_front();
                    check("rdataA", busA.Rdata, exp);
                    lastRdA = exp;
                end else begin
                    check("rdataHoldA", busA.Rdata, lastRdA);
                end
                done = 1'b1;
                break;
            end
            check("stallWaitA", {31'b0, busA.Stall}, 1);
        end
        check("timeoutA", {31'b0, done}, 1);
        if (wr && !(ALIGN_EN && addr[1:0] != 2'b00)) modelA[idx] = wdata;
        @(posedge clk);
        #1;
        busA.MemRead  = 1'b0;
        busA.MemWrite = 1'b0;
        @(negedge clk);
        check("idleReadyA", {31'b0, busA.MemReady}, 0);
        check("idleAddrErrA", {31'b0, busA.AddrErr}, 0);
        @(posedge clk);
        #1;
    endtask

    // One access on the 0-wait instance.
    task automatic accessB(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
        int idx;
        idx = int'(addr[9:2]);
        busB.MemRead  = rd;
        busB.MemWrite = wr;
        busB.Addr     = addr;
        busB.Wdata    = wdata;
        if (rd && !wr) qB.push_back(modelB.exists(idx) ? modelB[idx] : 32'h0);
        @(negedge clk);
        check("readyC0B", {31'b0, busB.MemReady}, 0);
        check("stallC0B", {31'b0, busB.Stall}, 1);
        @(negedge clk);
        check("readyC1B", {31'b0, busB.MemReady}, 1);
        if (rd && !wr) check("rdataB", busB.Rdata, qB.pop_front());
        if (wr) modelB[idx] = wdata;
        @(posedge clk);
        #1;
        busB.MemRead  = 1'b0;
        busB.MemWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        busA.MemRead = 1'b0; busA.MemWrite = 1'b0; busA.Addr = '0; busA.Wdata = '0;
        busB.MemRead = 1'b0; busB.MemWrite = 1'b0; busB.Addr = '0; busB.Wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rstReadyA", {31'b0, busA.MemReady}, 0);
        check("rstRdataA", busA.Rdata, 32'h0);
        check("rstAddrErrA", {31'b0, busA.AddrErr}, 0);
        check("rstStallA", {31'b0, busA.Stall}, 0);
        check("rstRdataB", busB.Rdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic write/read, then aliasing of 0x400 onto word 0.
        accessA(1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0);
        accessA(1'b1, 1'b0, 32'h10,  32'h0,        1'b0);
        accessA(1'b0, 1'b1, 32'h400, 32'h55,       1'b0);
        accessA(1'b1, 1'b0, 32'h0,   32'h0,        1'b0);
        accessA(1'b0, 1'b1, 32'h20,  32'h1111,     1'b0);
        accessA(1'b1, 1'b0, 32'h10,  32'h0,        1'b0);

        // Reset in the WAIT cycle of a write: the write must be discarded.
        busA.MemWrite = 1'b1;
        busA.Addr     = 32'h20;
        busA.Wdata    = 32'hA5A5;
        @(posedge clk);
        #1;
        reset         = 1'b1;
        busA.MemWrite = 1'b0;
        @(negedge clk);
        check("midRstReadyA", {31'b0, busA.MemReady}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("postRstRdataA", busA.Rdata, 32'h0);
        check("postRstReadyA", {31'b0, busA.MemReady}, 0);
        lastRdA = 32'h0;
        @(posedge clk);
        #1;
        accessA(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        // Read and write together behave as a write and leave Rdata alone.
        accessA(1'b1, 1'b1, 32'h8, 32'h7, 1'b0);
        accessA(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);

        // Misaligned write: only blocked when alignment checking is built in.
        accessA(1'b0, 1'b1, 32'h13, 32'hBEEF, ALIGN_EN);
        accessA(1'b1, 1'b0, 32'h10, 32'h0,    1'b0);

        // Zero-wait instance: preload, then back-to-back reads.
        accessB(1'b0, 1'b1, 32'h0, 32'h1);
        accessB(1'b0, 1'b1, 32'h4, 32'h2);
        busB.MemRead = 1'b1;
        busB.Addr    = 32'h0;
        qB.push_back(modelB[0]);
        @(negedge clk);
        check("b2bC0Ready", {31'b0, busB.MemReady}, 0);
        @(negedge clk);
        check("b2bC1Ready", {31'b0, busB.MemReady}, 1);
        check("b2bC1Rdata", busB.Rdata, qB.pop_front());
        @(posedge clk);
        #1;
        busB.Addr = 32'h4;
        qB.push_back(modelB[1]);
        @(negedge clk);
        check("b2bC2Ready", {31'b0, busB.MemReady}, 0);
        check("b2bC2Stall", {31'b0, busB.Stall}, 1);
        @(negedge clk);
        check("b2bC3Ready", {31'b0, busB.MemReady}, 1);
        check("b2bC3Rdata", busB.Rdata, qB.pop_front());
        @(posedge clk);
        #1;
        busB.MemRead = 1'b0;
        @(negedge clk);
        check("b2bHoldRdata", busB.Rdata, 32'h2);
        check("b2bIdleReady", {31'b0, busB.MemReady}, 0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
